cart_load_arbiter: RTL and testbench
====================================

// Module: cart_load_arbiter
// PURPOSE
//  Owns the shared cartridge memory port. Arbitrates between the HPS ioctl download
//  stream and console-side CPU reads, and holds the CPU while a cartridge is loading.
//  Tracks the loaded image size and valid flag for the rest of the core.
//  Sits in the core between hps_io ioctl_* signals and the cartridge ROM wrapper.
// PARAMETERS
//  ADDR_W  14     cartridge address width; memory holds 2^ADDR_W bytes
//  INDEX   1      ioctl_index[5:0] value accepted as a cartridge download
//  FILL    8'h00  byte written to unused space when CART_CLEAR_EN is defined
// PORTS
//  clk             in   1       system clock; the only clock
//  reset           in   1       synchronous, active-high
//  ioctl_download  in   1       HPS download active
//  ioctl_index     in   8       download file index
//  ioctl_wr        in   1       byte strobe
//  ioctl_addr      in   25      byte address
//  ioctl_dout      in   8       byte data
//  ioctl_wait      out  1       backpressure to HPS
//  cpu_req         in   1       CPU read request, held until cpu_ack
//  cpu_addr        in   ADDR_W  CPU read address
//  cpu_ack         out  1       1-cycle pulse: read complete
//  cpu_rdata       out  8       read data, valid while cpu_ack=1
//  cpu_hold        out  1       CPU must stall/reset while 1
//  mem_addr        out  ADDR_W  memory address
//  mem_wdata       out  8       memory write data
//  mem_we          out  1       write request
//  mem_re          out  1       read request
//  mem_ready       in   1       request accepted this cycle
//  mem_rdata       in   8       read data
//  mem_rvalid      in   1       read data valid
//  cart_size       out  ADDR_W+1  highest written address + 1, saturating at 2^ADDR_W
//  cart_valid      out  1       a complete image has been loaded
// BEHAVIOUR
//  - Reset values: state=RUN, buf_v=0, ioctl_wait=0, cpu_ack=0, cpu_rdata=0, cart_size=0,
//    cart_valid=0, mem_we=0, mem_re=0. Reset mid-load aborts the load and drops the buffer.
//  - FSM: RUN -> LOAD on ioctl_download=1 with ioctl_index[5:0]==INDEX.
//    Entering LOAD clears cart_size and cart_valid. Other indexes are ignored; stay in RUN.
//  - LOAD -> DRAIN on ioctl_download=0. DRAIN -> CLEAR (macro) or RUN once buf_v=0.
//    The transition into RUN sets cart_valid=1. cpu_hold = (state != RUN), combinational.
//  - Write buffer: one entry. ioctl_wr=1 && buf_v=0 in LOAD captures addr/data; buf_v=1 next cycle.
//  - ioctl_wait = buf_v (registered).
//  - ioctl_wr while buf_v=1 is dropped and does not update cart_size.
//  - ioctl_addr >= 2^ADDR_W is accepted, but not written; cart_size saturates at 2^ADDR_W.
//  - While buf_v=1: mem_we=1, mem_addr/mem_wdata come from the buffer.
//  - buf_v clears on the edge where mem_we && mem_ready. Peak rate: 1 byte per 2 cycles.
//  - cart_size <= max(cart_size, addr+1) on capture, in (ADDR_W+1)-bit arithmetic.
//  - CPU reads are served only in RUN. At most one read is outstanding.
//  - CPU read timing: mem_re = cpu_req && !outstanding; mem_addr = cpu_addr.
//    Acceptance (mem_ready) sets outstanding. On mem_rvalid: cpu_rdata <= mem_rdata and
//    cpu_ack <= 1 for 1 cycle; outstanding clears. Latency = accept + memory latency + 1.
//  - Priority when simultaneous: buffer write > clear write > CPU read.
//    CPU requests outside RUN get no ack.
//  - An outstanding read at LOAD entry completes internally. Its ack is suppressed.
//  - Simultaneous ioctl_download rise and cpu_req in RUN: LOAD wins; mem_re=0 that cycle.
// CONFIGURATION
//  CART_CLEAR_EN defined: DRAIN -> CLEAR. CLEAR writes FILL to addresses cart_size ..
//    2^ADDR_W-1, one per mem_ready, via an ADDR_W+1 counter. It exits to RUN when the
//    counter reaches 2^ADDR_W; it is skipped if cart_size==2^ADDR_W.
//    ioctl_download rising during CLEAR restarts LOAD.
//  CART_CLEAR_EN undefined: no CLEAR state. DRAIN -> RUN directly; memory past the image
//    keeps stale contents.
// TESTING
//  1. ADDR_W=14, load 4 bytes A5,5A,01,02 at 0..3, mem_ready=1
//     -> 4 writes, ioctl_wait high 1 cycle each, cart_size=4, cart_valid=1.
//  2. mem_ready=0 for 5 cycles during a buffered write -> ioctl_wait held 5+ cycles.
//     An extra ioctl_wr in that window is dropped: write count unchanged.
//  3. Download with index 2 -> no mem_we, cpu_hold stays 0, cart_size unchanged.
//  4. RUN, cpu_req addr 0x0003, memory latency 1 -> cpu_ack 3 cycles after request,
//     cpu_rdata=02. cpu_req during LOAD -> no ack, cpu_hold=1.
//  5. Address 0x4000 written with ADDR_W=14 -> no mem_we, cart_size=0x4000.
//     Reset mid-LOAD -> state RUN, cart_valid=0, ioctl_wait=0 next cycle.
//  6. CART_CLEAR_EN, 4-byte image -> 16380 FILL writes at 0x0004..0x3FFF, then cpu_hold=0.
//     Without the macro -> cpu_hold=0 two cycles after ioctl_download falls.

Source files
------------

// File: rtl/cart_load_arbiter.sv
// Cartridge memory port owner: arbitrates HPS ioctl downloads against CPU reads and tracks image size/valid.
// Optional build macro CART_CLEAR_EN adds a CLEAR pass that fills memory past the image with FILL.
module cart_load_arbiter #(
    parameter int         ADDR_W = 14,
    parameter logic [5:0] INDEX  = 6'd1,
    parameter logic [7:0] FILL   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic [ADDR_W:0]   cart_size,
    output logic              cart_valid
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MEM_BYTES = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic              buf_v;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              outstanding;
    logic              dl_match;
    logic              load_start;
    logic              in_range;
    logic [ADDR_W:0]   wr_end;
    logic              unused_bits;
`ifdef CART_CLEAR_EN
    logic [ADDR_W:0]   clr_cnt;
`endif

    assign unused_bits = ^ioctl_index[7:6];
    assign dl_match    = ioctl_download && (ioctl_index[5:0] == INDEX);
    assign load_start  = (state == ST_RUN) && dl_match;
    assign in_range    = ~|ioctl_addr[24:ADDR_W];
    // Out-of-range bytes still grow the image size, clamped to the memory size.
    assign wr_end      = in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1)) : MEM_BYTES;
    assign ioctl_wait  = buf_v;
    assign cpu_hold    = (state != ST_RUN);

    // NOTE: every output gets a default first so this block cannot infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = buf_data;
        if (!reset) begin
            if (buf_v) begin
                mem_we   = 1'b1;
                mem_addr = buf_addr;
            end
`ifdef CART_CLEAR_EN
            else if (state == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt[ADDR_W-1:0];
                mem_wdata = FILL;
            end
`endif
            else if ((state == ST_RUN) && cpu_req && !outstanding && !load_start) begin
                mem_re = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            buf_v       <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            outstanding <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            cart_size   <= '0;
            cart_valid  <= 1'b0;
`ifdef CART_CLEAR_EN
            clr_cnt     <= '0;
`endif
        end else begin
            cpu_ack <= 1'b0;
            if (mem_re && mem_ready) begin
                outstanding <= 1'b1;
            end
            // A read still in flight when a load starts completes silently.
            if (outstanding && mem_rvalid) begin
                outstanding <= 1'b0;
                cpu_rdata   <= mem_rdata;
                cpu_ack     <= (state == ST_RUN) && !load_start;
            end
            if (buf_v && mem_ready) begin
                buf_v <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (load_start) begin
                        state      <= ST_LOAD;
                        cart_size  <= '0;
                        cart_valid <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ioctl_wr && !buf_v) begin
                        buf_addr <= ioctl_addr[ADDR_W-1:0];
                        buf_data <= ioctl_dout;
                        buf_v    <= in_range;
                        if (wr_end > cart_size) begin
                            cart_size <= wr_end;
                        end
                    end
                    if (!ioctl_download) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!buf_v) begin
`ifdef CART_CLEAR_EN
                        if (cart_size == MEM_BYTES) begin
                            state      <= ST_RUN;
                            cart_valid <= 1'b1;
                        end else begin
                            state   <= ST_CLEAR;
                            clr_cnt <= cart_size;
                        end
`else
                        state      <= ST_RUN;
                        cart_valid <= 1'b1;
`endif
                    end
                end
`ifdef CART_CLEAR_EN
                ST_CLEAR: begin
                    if (dl_match) begin
                        state      <= ST_LOAD;
                        cart_size  <= '0;
                        cart_valid <= 1'b0;
                    end else if (mem_ready) begin
                        clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
                        if (clr_cnt == MEM_BYTES - (ADDR_W+1)'(1)) begin
                            state      <= ST_RUN;
                            cart_valid <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_load_arbiter.sv
// Bench for cart_load_arbiter: randomized ioctl/CPU traffic against a behavioural image model and RAM.
// Define CART_CLEAR_EN for both bench and RTL to exercise the fill pass.
module tb_cart_load_arbiter;

    localparam int         ADDR_W    = 14;
    localparam int         MEM_BYTES = 1 << ADDR_W;
    localparam logic [7:0] FILL      = 8'h00;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = '0;
    logic              ioctl_wait;
    logic              cpu_req = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_hold;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              mem_ready = 1'b0;
    logic [7:0]        mem_rdata = '0;
    logic              mem_rvalid = 1'b0;
    logic [ADDR_W:0]   cart_size;
    logic              cart_valid;

    cart_load_arbiter #(.ADDR_W(ADDR_W), .INDEX(6'd1), .FILL(FILL)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_hold(cpu_hold), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .cart_size(cart_size), .cart_valid(cart_valid)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural RAM on the far side of the port; lat is cycles from acceptance to rvalid.
    logic [7:0] ram [0:MEM_BYTES-1];
    int         wr_count  = 0;
    int         ready_pct = 100;
    int         lat       = 1;
    int         pend_cnt  = 0;
    logic [7:0] pend_data = '0;

    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (pend_cnt == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= pend_data;
        end
        if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
        if (mem_re && mem_ready) begin
            if (lat <= 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= ram[mem_addr];
            end else begin
                pend_data <= ram[mem_addr];
                pend_cnt  <= lat - 1;
            end
        end
        if (mem_we && mem_ready) begin
            ram[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
        mem_ready <= ($urandom_range(99) < ready_pct);
    end

    // Image model: one pending byte, expected contents, size and write count.
    logic        m_busy    = 1'b0;
    logic        m_in_load = 1'b0;
    logic [13:0] m_baddr   = '0;
    logic [7:0]  m_bdata   = '0;
    int          exp_size  = 0;
    int          exp_writes = 0;
    logic [7:0]  exp_mem [0:MEM_BYTES-1];

    task automatic tick();
        logic cap;
        int   wend;
        if (reset) begin
            m_busy = 1'b0;
        end else begin
            cap = m_in_load && ioctl_wr && !m_busy;
            if (m_busy && mem_ready) begin
                exp_mem[m_baddr] = m_bdata;
                exp_writes++;
                m_busy = 1'b0;
            end
            if (cap) begin
                wend = (int'(ioctl_addr) >= MEM_BYTES) ? MEM_BYTES : int'(ioctl_addr) + 1;
                if (wend > exp_size) exp_size = wend;
                if (int'(ioctl_addr) < MEM_BYTES) begin
                    m_busy  = 1'b1;
                    m_baddr = ioctl_addr[13:0];
                    m_bdata = ioctl_dout;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        tick();
        m_in_load = 1'b1;
        exp_size  = 0;
    endtask

    task automatic finish_load(input string tag);
        int n;
`ifdef CART_CLEAR_EN
        int base;
        int exp_fill;
`endif
        ioctl_wr  = 1'b0;
        ready_pct = 100;
        n = 0;
        while (m_busy && n < 200) begin tick(); n++; end
        ioctl_download = 1'b0;
        tick();
        m_in_load = 1'b0;
        n_total++;
        if (cpu_hold !== 1'b1) $display("FAIL %s drain_hold: got %b expected 1", tag, cpu_hold);
        else n_pass++;
`ifdef CART_CLEAR_EN
        exp_fill = (exp_size < MEM_BYTES) ? MEM_BYTES - exp_size : 0;
        base = wr_count;
        n = 0;
        while (cpu_hold === 1'b1 && n < 40000) begin tick(); n++; end
        n_total++;
        if (cpu_hold !== 1'b0) $display("FAIL %s clear_timeout: hold %b after %0d cycles", tag, cpu_hold, n);
        else n_pass++;
        n_total++;
        if (wr_count - base != exp_fill) $display("FAIL %s fill_writes: got %0d expected %0d", tag, wr_count - base, exp_fill);
        else n_pass++;
        for (int i = exp_size; i < MEM_BYTES; i++) exp_mem[i] = FILL;
        exp_writes += exp_fill;
        if (exp_fill > 0) begin
            n_total++;
            if (ram[MEM_BYTES-1] !== FILL) $display("FAIL %s fill_top: got %h expected %h", tag, ram[MEM_BYTES-1], FILL);
            else n_pass++;
        end
`else
        tick();
        n_total++;
        if (cpu_hold !== 1'b0) $display("FAIL %s hold_release: got %b expected 0 two cycles after fall", tag, cpu_hold);
        else n_pass++;
`endif
        n_total++;
        if (cart_valid !== 1'b1) $display("FAIL %s cart_valid: got %b expected 1", tag, cart_valid);
        else n_pass++;
        n_total++;
        if (cart_size !== 15'(exp_size)) $display("FAIL %s cart_size: got %0h expected %0h", tag, cart_size, exp_size);
        else n_pass++;
        n_total++;
        if (wr_count != exp_writes) $display("FAIL %s write_count: got %0d expected %0d", tag, wr_count, exp_writes);
        else n_pass++;
    endtask

    task automatic test_reset();
        cpu_req = 1'b1;
        cpu_addr = 14'h0010;
        tick();
        tick();
        n_total++;
        if (mem_re !== 1'b0) $display("FAIL reset mem_re: got %b expected 0", mem_re); else n_pass++;
        n_total++;
        if (mem_we !== 1'b0) $display("FAIL reset mem_we: got %b expected 0", mem_we); else n_pass++;
        n_total++;
        if (ioctl_wait !== 1'b0) $display("FAIL reset ioctl_wait: got %b expected 0", ioctl_wait); else n_pass++;
        n_total++;
        if (cpu_ack !== 1'b0) $display("FAIL reset cpu_ack: got %b expected 0", cpu_ack); else n_pass++;
        n_total++;
        if (cpu_rdata !== 8'h00) $display("FAIL reset cpu_rdata: got %h expected 00", cpu_rdata); else n_pass++;
        n_total++;
        if (cart_size !== 15'd0) $display("FAIL reset cart_size: got %0h expected 0", cart_size); else n_pass++;
        n_total++;
        if (cart_valid !== 1'b0) $display("FAIL reset cart_valid: got %b expected 0", cart_valid); else n_pass++;
        n_total++;
        if (cpu_hold !== 1'b0) $display("FAIL reset cpu_hold: got %b expected 0", cpu_hold); else n_pass++;
        cpu_req = 1'b0;
        reset   = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        logic [7:0] bytes [4];
        bytes = '{8'hA5, 8'h5A, 8'h01, 8'h02};
        ready_pct = 100;
        tick();
        start_load();
        n_total++;
        if (cpu_hold !== 1'b1) $display("FAIL basic hold_in_load: got %b expected 1", cpu_hold); else n_pass++;
        n_total++;
        if (cart_valid !== 1'b0) $display("FAIL basic valid_in_load: got %b expected 0", cart_valid); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = bytes[i];
            tick();
            ioctl_wr = 1'b0;
            n_total++;
            if (ioctl_wait !== m_busy) $display("FAIL basic wait_high[%0d]: got %b expected %b", i, ioctl_wait, m_busy); else n_pass++;
            n_total++;
            if (mem_we !== 1'b1 || mem_addr !== 14'(i) || mem_wdata !== bytes[i])
                $display("FAIL basic mem_write[%0d]: got we=%b a=%h d=%h expected we=1 a=%h d=%h", i, mem_we, mem_addr, mem_wdata, i, bytes[i]);
            else n_pass++;
            tick();
            n_total++;
            if (ioctl_wait !== m_busy) $display("FAIL basic wait_low[%0d]: got %b expected %b", i, ioctl_wait, m_busy); else n_pass++;
        end
        finish_load("basic");
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (ram[i] !== bytes[i]) $display("FAIL basic ram[%0d]: got %h expected %h", i, ram[i], bytes[i]); else n_pass++;
        end
    endtask

    task automatic test_cpu_read();
        int n;
        ready_pct = 100;
        lat = 1;
        tick();
        cpu_req  = 1'b1;
        cpu_addr = 14'h0003;
        n = 0;
        do begin tick(); n++; end while (cpu_ack !== 1'b1 && n < 20);
        // Ack lands in the third cycle of the request: accept, rvalid, ack.
        n_total++;
        if (n != 2) $display("FAIL read latency: got %0d edges expected 2", n); else n_pass++;
        n_total++;
        if (cpu_rdata !== 8'h02) $display("FAIL read data_at_3: got %h expected 02", cpu_rdata); else n_pass++;
        cpu_req = 1'b0;
        tick();
        n_total++;
        if (cpu_ack !== 1'b0) $display("FAIL read ack_pulse: got %b expected 0", cpu_ack); else n_pass++;

        // Load start and CPU request in the same cycle: the load wins.
        cpu_req        = 1'b1;
        cpu_addr       = 14'h0007;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd1;
        #1;
        n_total++;
        if (mem_re !== 1'b0) $display("FAIL read collide_mem_re: got %b expected 0", mem_re); else n_pass++;
        tick();
        m_in_load = 1'b1;
        exp_size  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (mem_re !== 1'b0 || cpu_ack !== 1'b0 || cpu_hold !== 1'b1)
                $display("FAIL read in_load[%0d]: got re=%b ack=%b hold=%b expected 0 0 1", i, mem_re, cpu_ack, cpu_hold);
            else n_pass++;
        end
        cpu_req = 1'b0;
        finish_load("empty");

        // A read accepted just before the load starts must not ack.
        lat      = 3;
        cpu_req  = 1'b1;
        cpu_addr = 14'h0005;
        #1;
        n_total++;
        if (mem_re !== 1'b1) $display("FAIL read idle_mem_re: got %b expected 1", mem_re); else n_pass++;
        tick();
        cpu_req = 1'b0;
        start_load();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if (cpu_ack !== 1'b0) $display("FAIL read suppressed_ack[%0d]: got %b expected 0", i, cpu_ack); else n_pass++;
        end
        finish_load("outstanding");
    endtask

    task automatic test_index_ignore();
        int base;
        base = wr_count;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd2;
        for (int i = 0; i < 6; i++) begin
            ioctl_wr   = i[0];
            ioctl_addr = 25'($urandom_range(0, 255));
            ioctl_dout = 8'($urandom);
            tick();
            n_total++;
            if (cpu_hold !== 1'b0 || mem_we !== 1'b0)
                $display("FAIL index hold_we[%0d]: got hold=%b we=%b expected 0 0", i, cpu_hold, mem_we);
            else n_pass++;
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        n_total++;
        if (cart_size !== 15'(exp_size)) $display("FAIL index cart_size: got %0h expected %0h", cart_size, exp_size); else n_pass++;
        n_total++;
        if (wr_count != base) $display("FAIL index writes: got %0d expected %0d", wr_count - base, 0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n;
        start_load();
        ready_pct = 0;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h10;
        ioctl_dout = 8'h77;
        tick();
        ioctl_wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'h11;
                ioctl_dout = 8'h88;
            end
            tick();
            ioctl_wr = 1'b0;
            n_total++;
            if (ioctl_wait !== 1'b1 || m_busy !== 1'b1 || mem_addr !== 14'h10)
                $display("FAIL bp stall[%0d]: got wait=%b addr=%h expected wait=1 addr=10", k, ioctl_wait, mem_addr);
            else n_pass++;
        end
        ready_pct = 100;
        n = 0;
        while (m_busy && n < 20) begin tick(); n++; end
        n_total++;
        if (ioctl_wait !== m_busy) $display("FAIL bp release: got %b expected %b", ioctl_wait, m_busy); else n_pass++;
        finish_load("backpressure");
        n_total++;
        if (cart_size !== 15'h11) $display("FAIL bp size_excludes_drop: got %0h expected 11", cart_size); else n_pass++;
        n_total++;
        if (ram[16] !== 8'h77 || ram[17] !== exp_mem[17])
            $display("FAIL bp ram: got %h %h expected 77 %h", ram[16], ram[17], exp_mem[17]);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [24:0] addrs [2];
        addrs = '{25'h4000, 25'h1FF_FFFF};
        start_load();
        for (int i = 0; i < 2; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = addrs[i];
            ioctl_dout = 8'hEE;
            tick();
            ioctl_wr = 1'b0;
            n_total++;
            if (mem_we !== 1'b0 || ioctl_wait !== 1'b0)
                $display("FAIL oor no_write[%0d]: got we=%b wait=%b expected 0 0", i, mem_we, ioctl_wait);
            else n_pass++;
            tick();
        end
        finish_load("out_of_range");
        n_total++;
        if (cart_size !== 15'h4000) $display("FAIL oor saturate: got %0h expected 4000", cart_size); else n_pass++;
    endtask

    task automatic test_random_load();
        start_load();
        ready_pct = $urandom_range(30, 100);
        for (int i = 0; i < 80; i++) begin
            ioctl_wr   = $urandom_range(1);
            ioctl_addr = ($urandom_range(19) == 0) ? 25'($urandom_range(MEM_BYTES, 25'h1FF_FFFF))
                                                   : 25'($urandom_range(0, 255));
            ioctl_dout = 8'($urandom);
            tick();
            n_total++;
            if (ioctl_wait !== m_busy || mem_we !== m_busy)
                $display("FAIL rand wait_we[%0d]: got wait=%b we=%b expected %b", i, ioctl_wait, mem_we, m_busy);
            else n_pass++;
        end
        finish_load("random");
    endtask

    task automatic test_random_reads(input int count);
        int n;
        logic [13:0] a;
        for (int i = 0; i < count; i++) begin
            lat       = $urandom_range(1, 3);
            ready_pct = $urandom_range(40, 100);
            a         = 14'($urandom_range(0, 255));
            cpu_req   = 1'b1;
            cpu_addr  = a;
            n = 0;
            do begin tick(); n++; end while (cpu_ack !== 1'b1 && n < 100);
            cpu_req = 1'b0;
            n_total++;
            if (cpu_ack !== 1'b1) $display("FAIL rread timeout[%0d]: no ack after %0d cycles", i, n);
            else if (cpu_rdata !== exp_mem[a]) $display("FAIL rread data[%0d]: addr %h got %h expected %h", i, a, cpu_rdata, exp_mem[a]);
            else n_pass++;
            tick();
            n_total++;
            if (cpu_ack !== 1'b0) $display("FAIL rread ack_pulse[%0d]: got %b expected 0", i, cpu_ack); else n_pass++;
        end
        ready_pct = 100;
    endtask

    task automatic test_reset_mid_load();
        start_load();
        ready_pct = 0;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h20;
        ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 1'b0;
        n_total++;
        if (ioctl_wait !== m_busy) $display("FAIL rst_mid buffered: got %b expected %b", ioctl_wait, m_busy); else n_pass++;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        m_in_load = 1'b0;
        exp_size  = 0;
        n_total++;
        if (ioctl_wait !== 1'b0 || cpu_hold !== 1'b0 || cart_valid !== 1'b0 || cart_size !== 15'd0 || mem_we !== 1'b0)
            $display("FAIL rst_mid state: got wait=%b hold=%b valid=%b size=%0h we=%b expected all 0",
                     ioctl_wait, cpu_hold, cart_valid, cart_size, mem_we);
        else n_pass++;
        reset     = 1'b0;
        ready_pct = 100;
        tick();
        tick();
        n_total++;
        if (wr_count != exp_writes || mem_we !== 1'b0)
            $display("FAIL rst_mid dropped: got writes=%0d we=%b expected %0d 0", wr_count, mem_we, exp_writes);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            ram[i]     = 8'(i) ^ 8'h3C;
            exp_mem[i] = 8'(i) ^ 8'h3C;
        end
        test_reset();
        test_basic_load();
        test_cpu_read();
        test_index_ignore();
        test_backpressure();
        test_out_of_range();
        test_random_load();
        test_random_reads(16);
        test_reset_mid_load();
        test_random_reads(4);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
